// File: rtl/sarm_pkg.sv
// Shared SARM pipeline types: per-stage metadata entry and forwarding constants.
// Register addresses are zero-extended into fixed-width entry fields.
package sarm_pkg;

    localparam int REG_W       = 4;
    // Storage width for register fields; supports register address widths up to 8 bits
    localparam int ENTRY_REG_W = 8;
    localparam int SEL_RF      = 0;

    typedef struct packed {
        logic                   valid;
        logic [ENTRY_REG_W-1:0] dest;
        logic                   wb_en;
        logic                   mem_r_en;
        logic [ENTRY_REG_W-1:0] src1;
        logic [ENTRY_REG_W-1:0] src2;
        logic                   two_src;
    } stage_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the SARM datapath (master) and the pipeline hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = sarm_pkg::REG_W,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
);

    logic             fwd_en;
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic             branch_taken;
    logic             mem_busy;

    logic             hazard;
    logic             freeze_front;
    logic             flush_front;
    logic             bubble_ex;
    logic             freeze_all;
    logic [SEL_W-1:0] sel_src1;
    logic [SEL_W-1:0] sel_src2;
    logic [CNT_W-1:0] hazard_cnt;
    logic [CNT_W-1:0] busy_cnt;

    modport master (
        output fwd_en, id_valid, id_src1, id_src2, id_two_src, id_dest,
               id_wb_en, id_mem_r_en, branch_taken, mem_busy,
        input  hazard, freeze_front, flush_front, bubble_ex, freeze_all,
               sel_src1, sel_src2, hazard_cnt, busy_cnt
    );

    modport slave (
        input  fwd_en, id_valid, id_src1, id_src2, id_two_src, id_dest,
               id_wb_en, id_mem_r_en, branch_taken, mem_busy,
        output hazard, freeze_front, flush_front, bubble_ex, freeze_all,
               sel_src1, sel_src2, hazard_cnt, busy_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-high reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// SARM pipeline control: tracks metadata for EXE..WB and derives stall, flush,
// bubble and EXE forwarding selects from it.
module pipe_hazard_ctrl
    import sarm_pkg::*;
#(
    parameter int TRACK = 3,
    parameter int REG_W = sarm_pkg::REG_W,
    parameter int SEL_W = $clog2(TRACK),
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    stage_entry_t           entries [TRACK];
    stage_entry_t           id_entry;
    logic [REG_W-1:0]       id_src1_r, id_src2_r, id_dest_r;
    logic [ENTRY_REG_W-1:0] id_src1_x, id_src2_x, id_dest_x;
    logic [TRACK-1:0]       raw_hit, stall_qual, fwd1_hit, fwd2_hit;
    logic                   hazard;
    logic [SEL_W-1:0]       sel1, sel2;

    assign id_src1_r = bus.id_src1;
    assign id_src2_r = bus.id_src2;
    assign id_dest_r = bus.id_dest;
    assign id_src1_x = ENTRY_REG_W'(id_src1_r);
    assign id_src2_x = ENTRY_REG_W'(id_src2_r);
    assign id_dest_x = ENTRY_REG_W'(id_dest_r);

    // Per-entry producer matches. The WB entry never stalls: its write lands in
    // the register file in the same cycle ID reads it.
    for (genvar k = 0; k < TRACK; k++) begin : g_match
        logic producer;
        assign producer      = entries[k].valid & entries[k].wb_en;
        assign raw_hit[k]    = producer &
                               ((entries[k].dest == id_src1_x) |
                                (bus.id_two_src & (entries[k].dest == id_src2_x)));
        assign stall_qual[k] = (k != TRACK-1) & (~bus.fwd_en | entries[k].mem_r_en);
        assign fwd1_hit[k]   = (k != 0) & producer &
                               (entries[k].dest == entries[0].src1) &
                               (~entries[k].mem_r_en | (k == TRACK-1));
        assign fwd2_hit[k]   = (k != 0) & producer & entries[0].two_src &
                               (entries[k].dest == entries[0].src2) &
                               (~entries[k].mem_r_en | (k == TRACK-1));
    end

    assign hazard = (|(raw_hit & stall_qual)) & bus.id_valid & ~bus.branch_taken;

    // Scan from the oldest entry down so the youngest producer overrides.
    always_comb begin
        sel1 = SEL_W'(SEL_RF);
        sel2 = SEL_W'(SEL_RF);
        if (bus.fwd_en && entries[0].valid) begin
            for (int k = TRACK-1; k >= 1; k--) begin
                if (fwd1_hit[k]) sel1 = SEL_W'(k);
                if (fwd2_hit[k]) sel2 = SEL_W'(k);
            end
        end
    end

    always_comb begin
        id_entry = '0;
        if (bus.id_valid && !hazard && !bus.branch_taken) begin
            id_entry.valid    = 1'b1;
            id_entry.dest     = id_dest_x;
            id_entry.wb_en    = bus.id_wb_en;
            id_entry.mem_r_en = bus.id_mem_r_en;
            id_entry.src1     = id_src1_x;
            id_entry.src2     = id_src2_x;
            id_entry.two_src  = bus.id_two_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TRACK; k++) entries[k] <= '0;
        end else if (!bus.mem_busy) begin
            entries[0] <= id_entry;
            for (int k = 1; k < TRACK; k++) entries[k] <= entries[k-1];
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard & ~bus.mem_busy),
        .count (bus.hazard_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_busy_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.mem_busy),
        .count (bus.busy_cnt)
    );

    // A taken branch waits out mem_busy; EXE is frozen so the branch stays visible.
    assign bus.hazard       = hazard;
    assign bus.freeze_front = hazard | bus.mem_busy;
    assign bus.flush_front  = bus.branch_taken & ~bus.mem_busy;
    assign bus.bubble_ex    = (hazard | bus.branch_taken) & ~bus.mem_busy;
    assign bus.freeze_all   = bus.mem_busy;
    assign bus.sel_src1     = sel1;
    assign bus.sel_src2     = sel2;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised scoreboard bench: two controllers (TRACK=3/CNT_W=4 and TRACK=5/CNT_W=16)
// share stimulus and are checked against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int NCYC = 1500;

    typedef struct {
        bit v;
        int dest;
        bit wb;
        bit ld;
        int s1;
        int s2;
        bit two;
    } rec_t;

    typedef struct {
        bit hz, ff, fl, bx, fa;
        int s1, s2, hc, bc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(4), .SEL_W(2), .CNT_W(4))  bus_a ();
    pipe_hazard_ctrl_if #(.REG_W(4), .SEL_W(3), .CNT_W(16)) bus_b ();

    pipe_hazard_ctrl #(.TRACK(3), .REG_W(4), .SEL_W(2), .CNT_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    pipe_hazard_ctrl #(.TRACK(5), .REG_W(4), .SEL_W(3), .CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model state: pipe[m][age], age 0 = EXE, age TRACK-1 = WB
    rec_t pipe [2][5];
    int   hcnt [2];
    int   bcnt [2];
    exp_t qa[$];
    exp_t qb[$];
    exp_t last_a, last_b;

    bit s_rst, s_fwd, s_idv, s_two, s_wb, s_ld, s_br, s_busy;
    int s_src1, s_src2, s_dest;

    function automatic rec_t bubble();
        rec_t r;
        r = '{v: 1'b0, dest: 0, wb: 1'b0, ld: 1'b0, s1: 0, s2: 0, two: 1'b0};
        return r;
    endfunction

    function automatic bit produces(rec_t r, int reg_no);
        return r.v && r.wb && (r.dest == reg_no);
    endfunction

    function automatic void resetModel(int m);
        for (int i = 0; i < 5; i++) pipe[m][i] = bubble();
        hcnt[m] = 0;
        bcnt[m] = 0;
    endfunction

    function automatic exp_t predict(int m, int tr);
        exp_t e;
        rec_t exe;
        e.hz = 1'b0;
        for (int age = 0; age < tr - 1; age++) begin
            if ((produces(pipe[m][age], s_src1) || (s_two && produces(pipe[m][age], s_src2)))
                && (!s_fwd || pipe[m][age].ld))
                e.hz = 1'b1;
        end
        e.hz = e.hz && s_idv && !s_br;
        e.ff = e.hz || s_busy;
        e.fl = s_br && !s_busy;
        e.bx = (e.hz || s_br) && !s_busy;
        e.fa = s_busy;
        e.s1 = 0;
        e.s2 = 0;
        exe  = pipe[m][0];
        if (s_fwd && exe.v) begin
            for (int age = 1; age < tr; age++) begin
                if (e.s1 == 0 && produces(pipe[m][age], exe.s1) &&
                    (!pipe[m][age].ld || age == tr - 1))
                    e.s1 = age;
                if (e.s2 == 0 && exe.two && produces(pipe[m][age], exe.s2) &&
                    (!pipe[m][age].ld || age == tr - 1))
                    e.s2 = age;
            end
        end
        e.hc = hcnt[m];
        e.bc = bcnt[m];
        return e;
    endfunction

    function automatic void advance(int m, int tr, int cmax, exp_t e);
        rec_t issued;
        if (s_rst) begin
            resetModel(m);
            return;
        end
        if (e.hz && !s_busy && hcnt[m] < cmax) hcnt[m]++;
        if (s_busy && bcnt[m] < cmax) bcnt[m]++;
        if (!s_busy) begin
            for (int age = tr - 1; age >= 1; age--) pipe[m][age] = pipe[m][age-1];
            issued = bubble();
            if (s_idv && !e.hz && !s_br)
                issued = '{v: 1'b1, dest: s_dest, wb: s_wb, ld: s_ld,
                           s1: s_src1, s2: s_src2, two: s_two};
            pipe[m][0] = issued;
        end
    endfunction

    function automatic int pickReg();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 15));
        return int'($urandom_range(0, 3));
    endfunction

    task automatic driveBus();
        rst                = s_rst;
        bus_a.fwd_en       = s_fwd;        bus_b.fwd_en       = s_fwd;
        bus_a.id_valid     = s_idv;        bus_b.id_valid     = s_idv;
        bus_a.id_src1      = 4'(s_src1);   bus_b.id_src1      = 4'(s_src1);
        bus_a.id_src2      = 4'(s_src2);   bus_b.id_src2      = 4'(s_src2);
        bus_a.id_two_src   = s_two;        bus_b.id_two_src   = s_two;
        bus_a.id_dest      = 4'(s_dest);   bus_b.id_dest      = 4'(s_dest);
        bus_a.id_wb_en     = s_wb;         bus_b.id_wb_en     = s_wb;
        bus_a.id_mem_r_en  = s_ld;         bus_b.id_mem_r_en  = s_ld;
        bus_a.branch_taken = s_br;         bus_b.branch_taken = s_br;
        bus_a.mem_busy     = s_busy;       bus_b.mem_busy     = s_busy;
    endtask

    // fwd_en only changes on scheduled reset cycles so it is static outside reset.
    task automatic applyStimulus(int cyc);
        bit sched;
        sched  = (cyc % 250 == 0);
        s_rst  = sched || ($urandom_range(0, 99) == 0);
        if (sched) s_fwd = ((cyc / 250) % 2) == 1;
        s_busy = s_busy ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 2);
        s_br   = $urandom_range(0, 9) == 0;
        s_idv  = $urandom_range(0, 99) < 85;
        s_two  = $urandom_range(0, 1) == 1;
        s_wb   = $urandom_range(0, 3) != 0;
        s_ld   = $urandom_range(0, 99) < 35;
        s_src1 = pickReg();
        s_src2 = pickReg();
        s_dest = pickReg();
        driveBus();
        last_a = predict(0, 3);
        last_b = predict(1, 5);
        qa.push_back(last_a);
        qb.push_back(last_b);
    endtask

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                checkOutput("A.hazard",       32'(bus_a.hazard),       32'(e.hz));
                checkOutput("A.freeze_front", 32'(bus_a.freeze_front), 32'(e.ff));
                checkOutput("A.flush_front",  32'(bus_a.flush_front),  32'(e.fl));
                checkOutput("A.bubble_ex",    32'(bus_a.bubble_ex),    32'(e.bx));
                checkOutput("A.freeze_all",   32'(bus_a.freeze_all),   32'(e.fa));
                checkOutput("A.sel_src1",     32'(bus_a.sel_src1),     32'(e.s1));
                checkOutput("A.sel_src2",     32'(bus_a.sel_src2),     32'(e.s2));
                checkOutput("A.hazard_cnt",   32'(bus_a.hazard_cnt),   32'(e.hc));
                checkOutput("A.busy_cnt",     32'(bus_a.busy_cnt),     32'(e.bc));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                checkOutput("B.hazard",       32'(bus_b.hazard),       32'(e.hz));
                checkOutput("B.freeze_front", 32'(bus_b.freeze_front), 32'(e.ff));
                checkOutput("B.flush_front",  32'(bus_b.flush_front),  32'(e.fl));
                checkOutput("B.bubble_ex",    32'(bus_b.bubble_ex),    32'(e.bx));
                checkOutput("B.freeze_all",   32'(bus_b.freeze_all),   32'(e.fa));
                checkOutput("B.sel_src1",     32'(bus_b.sel_src1),     32'(e.s1));
                checkOutput("B.sel_src2",     32'(bus_b.sel_src2),     32'(e.s2));
                checkOutput("B.hazard_cnt",   32'(bus_b.hazard_cnt),   32'(e.hc));
                checkOutput("B.busy_cnt",     32'(bus_b.busy_cnt),     32'(e.bc));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        s_rst = 1'b1; s_fwd = 1'b0; s_idv = 1'b0; s_two = 1'b0; s_wb = 1'b0;
        s_ld = 1'b0; s_br = 1'b0; s_busy = 1'b0;
        s_src1 = 0; s_src2 = 0; s_dest = 0;
        driveBus();
        repeat (2) @(posedge clk);
        #1;
        resetModel(0);
        resetModel(1);
        $display("[TB] starting %0d randomised cycles", NCYC);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            applyStimulus(cyc);
            @(posedge clk);
            advance(0, 3, 15, last_a);
            advance(1, 5, 65535, last_b);
            #1;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d/%0d expectations left, required 0/0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
